// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/RV64I decode stage, registered output + 1-entry skid.
// Ports: IF handshake (in_valid_i/in_ready_o, instr_i, pc_i), regfile read
//   (rs*_addr_o, rs*_data_i), writeback (wb_*), flush_i, EX bundle (out_*).
// Optional: define ID_BYPASS_EN to forward wb_data_i onto matching operands.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              flush_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              rd_we_o,
  output logic [3:0]        funct_o,
  output logic [5:0]        fmt_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [3:0]        funct;
    logic [5:0]        fmt;
    logic              illegal;
  } bundle_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_J   = 7'b1101111;

  logic [6:0]        op;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1a;
  logic [REG_AW-1:0] rs2a;
  logic [REG_AW-1:0] rda;
  logic [5:0]        fmt;
  logic [31:0]       imm32;
  logic [3:0]        funct;
  logic              use1;
  logic              use2;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  bundle_t           dec;
  bundle_t           out_q;
  bundle_t           skid_q;
  bundle_t           skid_fwd;
  logic              out_valid;
  logic              skid_valid;
  logic              accept;
  logic              skid_load;

  assign op   = instr_i[6:0];
  assign f3   = instr_i[14:12];
  assign rs1a = REG_AW'(instr_i[19:15]);
  assign rs2a = REG_AW'(instr_i[24:20]);
  assign rda  = REG_AW'(instr_i[11:7]);

  assign rs1_addr_o = rs1a;
  assign rs2_addr_o = rs2a;

  always_comb begin
    fmt = '0;
    unique case (op)
      OP_R:                  fmt = 6'b000001;
      OP_IMM, OP_LD, OP_JLR: fmt = 6'b000010;
      OP_S:                  fmt = 6'b000100;
      OP_B:                  fmt = 6'b001000;
      OP_LUI, OP_AUI:        fmt = 6'b010000;
      OP_J:                  fmt = 6'b100000;
      default:               fmt = '0;
    endcase
  end

  always_comb begin
    imm32 = '0;
    funct = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    unique case (1'b1)
      fmt[0]: begin
        funct = {instr_i[30], f3};
        use1  = 1'b1;
        use2  = 1'b1;
      end
      fmt[1]: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        // shift-right-immediate carries the arith/logic select in bit 30
        funct = (op == OP_IMM && f3 == 3'b101) ?
                {instr_i[30], f3} : {1'b0, f3};
        use1  = 1'b1;
      end
      fmt[2]: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                 instr_i[11:7]};
        funct = {1'b0, f3};
        use1  = 1'b1;
        use2  = 1'b1;
      end
      fmt[3]: begin
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
        funct = {1'b0, f3};
        use1  = 1'b1;
        use2  = 1'b1;
      end
      fmt[4]: imm32 = {instr_i[31:12], 12'b0};
      fmt[5]: imm32 = {{11{instr_i[31]}}, instr_i[31],
                       instr_i[19:12], instr_i[20],
                       instr_i[30:21], 1'b0};
      default: ;
    endcase
  end

`ifdef ID_BYPASS_EN
  // the same-cycle writeback wins over the stale regfile read
  assign op1 = !(use1 && rs1a != '0) ? '0 :
               (wb_en_i && wb_addr_i == rs1a) ? wb_data_i : rs1_data_i;
  assign op2 = !(use2 && rs2a != '0) ? '0 :
               (wb_en_i && wb_addr_i == rs2a) ? wb_data_i : rs2_data_i;
`else
  assign op1 = (use1 && rs1a != '0) ? rs1_data_i : '0;
  assign op2 = (use2 && rs2a != '0) ? rs2_data_i : '0;
  logic unused_wb;
  assign unused_wb = ^{wb_en_i, wb_addr_i, wb_data_i};
`endif

  always_comb begin
    dec         = '0;
    dec.pc      = pc_i;
    dec.rs1     = op1;
    dec.rs2     = op2;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.illegal = (fmt == '0);
    dec.funct   = funct;
    dec.rd_we   = (fmt[0] | fmt[1] | fmt[4] | fmt[5]) && rda != '0;
    dec.rd      = dec.rd_we ? rda : '0;
  end

  assign accept    = in_valid_i && !skid_valid && !flush_i;
  assign skid_load = accept && out_valid && !out_ready_i;

`ifdef ID_BYPASS_EN
  // the skid keeps the source addresses so it can keep snooping writeback
  logic [REG_AW-1:0] skid_rs1a;
  logic [REG_AW-1:0] skid_rs2a;
  logic              skid_use1;
  logic              skid_use2;

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      skid_rs1a <= '0;
      skid_rs2a <= '0;
      skid_use1 <= 1'b0;
      skid_use2 <= 1'b0;
    end else if (skid_load) begin
      skid_rs1a <= rs1a;
      skid_rs2a <= rs2a;
      skid_use1 <= use1 && rs1a != '0;
      skid_use2 <= use2 && rs2a != '0;
    end
  end

  always_comb begin
    skid_fwd = skid_q;
    if (wb_en_i && skid_use1 && wb_addr_i == skid_rs1a)
      skid_fwd.rs1 = wb_data_i;
    if (wb_en_i && skid_use2 && wb_addr_i == skid_rs2a)
      skid_fwd.rs2 = wb_data_i;
  end
`else
  assign skid_fwd = skid_q;
`endif

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready_i) begin
      if (skid_valid) begin
        out_q      <= skid_fwd;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (skid_load) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end else if (skid_valid) begin
      skid_q <= skid_fwd;
    end
  end

  assign in_ready_o  = !skid_valid;
  assign out_valid_o = out_valid;
  assign pc_o        = out_q.pc;
  assign rs1_data_o  = out_q.rs1;
  assign rs2_data_o  = out_q.rs2;
  assign imm_o       = out_q.imm;
  assign rd_o        = out_q.rd;
  assign rd_we_o     = out_q.rd_we;
  assign funct_o     = out_q.funct;
  assign fmt_o       = out_q.fmt;
  assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed bench for id_stage_pipe, XLEN=32 and XLEN=64
// instances share stimulus; expected values are hand-computed constants.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        wb_en;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1d;
  logic [31:0] rs2d;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;

  logic        in_ready, out_valid, rd_we, illegal;
  logic [4:0]  rs1a, rs2a, rd;
  logic [31:0] pc_o, r1o, r2o, imm;
  logic [3:0]  funct;
  logic [5:0]  fmt;

  logic        in_ready_w, out_valid_w, rd_we_w, illegal_w;
  logic [4:0]  rs1a_w, rs2a_w, rd_w;
  logic [63:0] pc_w, r1_w, r2_w, imm_w;
  logic [3:0]  funct_w;
  logic [5:0]  fmt_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .REG_AW(5)) u32 (
    .clk_sys_i(clk), .rst_sys_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush),
    .rs1_addr_o(rs1a), .rs2_addr_o(rs2a),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .rs1_data_o(r1o), .rs2_data_o(r2o),
    .imm_o(imm), .rd_o(rd), .rd_we_o(rd_we),
    .funct_o(funct), .fmt_o(fmt), .illegal_o(illegal)
  );

  id_stage_pipe #(.XLEN(64), .REG_AW(5)) u64 (
    .clk_sys_i(clk), .rst_sys_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w),
    .instr_i(instr), .pc_i({32'h0, pc}), .flush_i(flush),
    .rs1_addr_o(rs1a_w), .rs2_addr_o(rs2a_w),
    .rs1_data_i({32'h0, rs1d}), .rs2_data_i({32'h0, rs2d}),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i({32'h0, wb_data}),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready),
    .pc_o(pc_w), .rs1_data_o(r1_w), .rs2_data_o(r2_w),
    .imm_o(imm_w), .rd_o(rd_w), .rd_we_o(rd_we_w),
    .funct_o(funct_w), .fmt_o(fmt_w), .illegal_o(illegal_w)
  );

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    instr = '0; pc = '0; rs1d = '0; rs2d = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid === 1'b0);
    chk("rst_in_ready", in_ready === 1'b1);
    chk("rst_imm", imm === 32'h0);
    chk("rst_fmt", fmt === 6'h0);
    chk("rst_rd_we", rd_we === 1'b0);
    chk("rst_w_valid", out_valid_w === 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    in_valid = 1'b1; instr = 32'hFFF08293; pc = 32'h100;
    rs1d = 32'h7; rs2d = 32'h9;
    #1;
    chk("addi_rs1a", rs1a === 5'd1);
    chk("addi_rs2a", rs2a === 5'd31);
    tick();
    chk("addi_valid", out_valid === 1'b1);
    chk("addi_pc", pc_o === 32'h100);
    chk("addi_rs1", r1o === 32'h7);
    chk("addi_rs2", r2o === 32'h0);
    chk("addi_imm", imm === 32'hFFFFFFFF);
    chk("addi_rd", rd === 5'd5);
    chk("addi_rd_we", rd_we === 1'b1);
    chk("addi_funct", funct === 4'b0000);
    chk("addi_fmt", fmt === 6'b000010);
    chk("addi_ill", illegal === 1'b0);
    chk("addi_imm64", imm_w === 64'hFFFF_FFFF_FFFF_FFFF);

    instr = 32'h402081B3; pc = 32'h104;
    tick();
    chk("sub_funct", funct === 4'b1000);
    chk("sub_fmt", fmt === 6'b000001);
    chk("sub_rd", rd === 5'd3);
    chk("sub_rs2", r2o === 32'h9);
    chk("sub_imm", imm === 32'h0);
    chk("sub_funct64", funct_w === 4'b1000);
    chk("sub_fmt64", fmt_w === 6'b000001);
    chk("sub_rd64", rd_w === 5'd3);

    instr = 32'hFE000EE3;
    tick();
    chk("beq_imm", imm === 32'hFFFFFFFC);
    chk("beq_imm64", imm_w === 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rd_we", rd_we === 1'b0);
    chk("beq_rd", rd === 5'd0);
    chk("beq_fmt", fmt === 6'b001000);
    chk("beq_rs1_x0", r1o === 32'h0);

    instr = 32'h123453B7;
    tick();
    chk("lui_imm", imm === 32'h12345000);
    chk("lui_fmt", fmt === 6'b010000);
    chk("lui_rd", rd === 5'd7);
    chk("lui_rs1", r1o === 32'h0);
    chk("lui_funct", funct === 4'h0);

    instr = 32'h0080006F;
    tick();
    chk("jal_imm", imm === 32'h8);
    chk("jal_fmt", fmt === 6'b100000);
    chk("jal_rd_we", rd_we === 1'b0);

    instr = 32'hFE20AC23;
    tick();
    chk("sw_imm", imm === 32'hFFFFFFF8);
    chk("sw_fmt", fmt === 6'b000100);
    chk("sw_funct", funct === 4'b0010);
    chk("sw_rs2", r2o === 32'h9);
    chk("sw_rd", rd === 5'd0);

    instr = 32'h4030D213;
    tick();
    chk("srai_funct", funct === 4'b1101);
    chk("srai_imm", imm === 32'h403);

    instr = 32'hFFFFFFFF;
    tick();
    chk("ill_valid", out_valid === 1'b1);
    chk("ill_flag", illegal === 1'b1);
    chk("ill_fmt", fmt === 6'h0);
    chk("ill_imm", imm === 32'h0);
    chk("ill_rd_we", rd_we === 1'b0);

    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid === 1'b0);

    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100313;
    tick();
    chk("st_a_valid", out_valid === 1'b1);
    chk("st_a_ready", in_ready === 1'b1);
    instr = 32'h00200393;
    tick();
    chk("st_b_ready", in_ready === 1'b0);
    chk("st_hold_rd", rd === 5'd6);
    instr = 32'h00300413;
    tick();
    chk("st_hold2_rd", rd === 5'd6);
    chk("st_hold2_rdy", in_ready === 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("st_b_valid", out_valid === 1'b1);
    chk("st_b_rd", rd === 5'd7);
    chk("st_b_imm", imm === 32'h2);
    chk("st_rel_ready", in_ready === 1'b1);
    tick();
    chk("st_c_dropped", out_valid === 1'b0);

    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100313;
    tick();
    instr = 32'h00200393;
    tick();
    chk("fl_pre_ready", in_ready === 1'b0);
    flush = 1'b1; instr = 32'h00300413;
    tick();
    chk("fl_valid", out_valid === 1'b0);
    chk("fl_ready", in_ready === 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_none1", out_valid === 1'b0);
    tick();
    chk("fl_none2", out_valid === 1'b0);

    flush = 1'b1; in_valid = 1'b1;
    tick();
    chk("fl_empty", out_valid === 1'b0);
    flush = 1'b0; in_valid = 1'b0;

    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100313;
    tick();
    instr = 32'h00200393;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid === 1'b0);
    chk("mrst_ready", in_ready === 1'b1);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("mrst_noreplay", out_valid === 1'b0);

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    rs1d = 32'h11; in_valid = 1'b1; instr = 32'hFFF08293;
    tick();
`ifdef ID_BYPASS_EN
    chk("byp_x1", r1o === 32'h55);
`else
    chk("byp_x1", r1o === 32'h11);
`endif
    instr = 32'hFFF00293;
    tick();
    chk("byp_x0", r1o === 32'h0);
    in_valid = 1'b0; wb_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
